// File: rtl/pkg_rv_decode.sv
// rtl/pkg_rv_decode.sv - decode types shared by the execute stage and the divider
package pkg_rv_decode;

    typedef logic [31:0]        u32_t;
    typedef logic signed [31:0] s32_t;

    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic is_div(alu_t op);
        return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    function automatic logic is_signed_div(alu_t op);
        return (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    function automatic logic is_rem(alu_t op);
        return (op == ALU_REM) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/rv_div_step.sv
// rtl/rv_div_step.sv - one combinational restoring division step
module rv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic            msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            qbit
);

    logic [XLEN:0] trial;

    // Shift the next dividend bit in and subtract the divisor when it fits.
    // The partial remainder is always below the divisor, so the trial needs
    // one extra bit and the difference always fits back into XLEN bits.
    always_comb begin
        trial    = {rem, msb};
        qbit     = (trial >= {1'b0, divisor});
        rem_next = qbit ? (trial[XLEN-1:0] - divisor) : trial[XLEN-1:0];
    end

endmodule

// File: rtl/rv_divider.sv
// rtl/rv_divider.sv - sequential radix-2 restoring divider for DIV/DIVU/REM/REMU
module rv_divider
    import pkg_rv_decode::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rdy,
    input  alu_t            alu,
    input  logic [XLEN-1:0] rrd1,
    input  logic [XLEN-1:0] rrd2,
    output logic [XLEN-1:0] rwdat,
    output logic            cmpl
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] dvd;
    logic [XLEN-1:0] dvs;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] res;
    logic            neg_q;
    logic            neg_r;
    alu_t            op_q;

    logic [XLEN-1:0] rem_next;
    logic            qbit;

    logic            in_sgn;
    logic            in_s1;
    logic            in_s2;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;

    logic [XLEN-1:0] quo_fin;
    logic [XLEN-1:0] q_out;
    logic [XLEN-1:0] r_out;
    logic [XLEN-1:0] fin;

    rv_div_step #(.XLEN(XLEN)) u_step (
        .rem      (rem_q),
        .msb      (dvd[XLEN-1]),
        .divisor  (dvs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    // Operand conditioning: signed ops divide magnitudes, unsigned ops use raw values.
    always_comb begin
        in_sgn = is_signed_div(alu);
        in_s1  = in_sgn & rrd1[XLEN-1];
        in_s2  = in_sgn & rrd2[XLEN-1];
        in_a   = in_s1 ? -rrd1 : rrd1;
        in_b   = in_s2 ? -rrd2 : rrd2;
    end

    // Sign fix-up and result select, evaluated on the last CALC step.
    always_comb begin
        quo_fin = {quo[XLEN-2:0], qbit};
        q_out   = neg_q ? -quo_fin : quo_fin;
        r_out   = neg_r ? -rem_next : rem_next;
        fin     = is_rem(op_q) ? r_out : q_out;
    end

    // Divider control FSM and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dvs   <= '0;
            rem_q <= '0;
            quo   <= '0;
            res   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            op_q  <= ALU_ADD;
        end else begin
            case (state)
                IDLE: begin
                    if (is_div(alu)) begin
                        op_q  <= alu;
                        neg_q <= in_s1 ^ in_s2;
                        neg_r <= in_s1;
                        dvd   <= in_a;
                        dvs   <= in_b;
                        rem_q <= '0;
                        quo   <= '0;
                        if (rrd2 == '0) begin
                            res   <= is_rem(alu) ? rrd1 : '1;
                            state <= DONE;
                        end else if (in_sgn && (rrd1 == MIN_NEG) && (rrd2 == '1)) begin
                            res   <= is_rem(alu) ? '0 : MIN_NEG;
                            state <= DONE;
                        end else begin
                            cnt   <= CW'(XLEN - 1);
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (!is_div(alu)) begin
                        state <= IDLE;
                    end else begin
                        dvd   <= {dvd[XLEN-2:0], 1'b0};
                        rem_q <= rem_next;
                        quo   <= quo_fin;
                        cnt   <= cnt - 1'b1;
                        if (cnt == '0) begin
                            res   <= fin;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (rdy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs depend only on state and the decoded op.
    always_comb begin
        cmpl  = (state == DONE) || !is_div(alu);
        rwdat = (state == DONE) ? res : '0;
    end

endmodule
